// File: rtl/blink_pkg.sv
// ----------------------------------------------------------------------------
// blink_pkg
// Definitions shared by the LED blinker and the blink period meter.
//   meter_state_t    : period meter FSM encoding (S_IDLE, S_MEASURE)
//   CLK_PER_MS_50MHZ : clk cycles per millisecond on the 50 MHz board
// ----------------------------------------------------------------------------
package blink_pkg;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } meter_state_t;

    localparam int CLK_PER_MS_50MHZ = 50000;

endpackage : blink_pkg

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous input into the clk domain through a flop chain and
// flags its edges. Also used for the board's push-button inputs.
//
// Parameters:
//   SYNC_STAGES : synchronizer flop count (must be 2 or more)
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset (clears chain and delay flop)
//   i_async_in in  asynchronous input
//   o_sync_out out synchronized level
//   o_sync_d   out o_sync_out delayed one cycle
//   o_rise     out one-cycle pulse on a 0->1 change of o_sync_out
//   o_fall     out one-cycle pulse on a 1->0 change of o_sync_out
//   o_any      out o_rise | o_fall
// ----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async_in,
    output logic o_sync_out,
    output logic o_sync_d,
    output logic o_rise,
    output logic o_fall,
    output logic o_any
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync_out = r_sync[SYNC_STAGES-1];
    assign o_sync_d   = r_sync_d;
    assign o_rise     =  o_sync_out & ~r_sync_d;
    assign o_fall     = ~o_sync_out &  r_sync_d;
    assign o_any      =  o_sync_out ^  r_sync_d;

endmodule : sync_edge_det

// File: rtl/blink_period_meter.sv
// ----------------------------------------------------------------------------
// blink_period_meter
// Measures the time between level changes of an asynchronous toggling input
// (e.g. a blinker LED line) in whole milliseconds. The first edge after reset
// or after a timeout only arms the meter; every later edge publishes the
// interval since the previous edge.
//
// Build option:
//   BLINK_METER_FULL_PERIOD_EN : when defined only rising edges are counted,
//   so o_period_ms reports the full blink period and o_period_lvl is tied 0.
//
// Parameters:
//   CLK_PER_MS  : clk cycles per millisecond tick
//   CNT_W       : width of the ms counter and of o_period_ms
//   SYNC_STAGES : synchronizer depth (2 or more)
// Ports:
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   i_sig_in     in  asynchronous toggling input
//   o_period_ms  out last measured interval in ms, holds between updates
//   o_period_vld out one-cycle pulse when o_period_ms updates
//   o_period_lvl out input level during the measured interval
//   o_timeout    out sticky: no edge for 2^CNT_W ms while measuring
// ----------------------------------------------------------------------------
module blink_period_meter
    import blink_pkg::*;
#(
    parameter int CLK_PER_MS  = CLK_PER_MS_50MHZ,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sig_in,
    output logic [CNT_W-1:0] o_period_ms,
    output logic             o_period_vld,
    output logic             o_period_lvl,
    output logic             o_timeout
);

    localparam int               PRESC_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    // ------------------------------------------------------------------
    // Synchronizer and edge detection
    // ------------------------------------------------------------------
    logic w_sync_out;
    logic w_sync_d;
    logic w_rise;
    logic w_fall;
    logic w_any;
    logic w_edge;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk        (clk),
        .rst        (rst),
        .i_async_in (i_sig_in),
        .o_sync_out (w_sync_out),
        .o_sync_d   (w_sync_d),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_any      (w_any)
    );

`ifdef BLINK_METER_FULL_PERIOD_EN
    // Falling edges are invisible: no prescaler restart, no capture.
    assign w_edge = w_rise;
    logic w_unused_edge;
    assign w_unused_edge = ^{w_sync_out, w_sync_d, w_fall, w_any};
`else
    assign w_edge = w_any;
    logic w_unused_edge;
    assign w_unused_edge = ^{w_sync_out, w_rise, w_fall};
`endif

    // ------------------------------------------------------------------
    // Millisecond prescaler: free-running, restarted by every edge so the
    // ms count is phase-aligned to the start of the interval.
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_edge || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    meter_state_t     r_state;
    meter_state_t     w_state_next;
    logic             w_arm;      // IDLE edge: start measuring
    logic             w_capture;  // MEASURE edge: publish interval
    logic             w_expire;   // MEASURE overflow: raise timeout

    logic [CNT_W-1:0] r_ms_cnt;
    logic             w_ms_full;
    logic [CNT_W-1:0] w_capture_val;

    assign w_ms_full = (r_ms_cnt == CNT_MAX);
    // A tick coinciding with the edge belongs to the closing interval;
    // the captured value saturates instead of wrapping.
    assign w_capture_val = (w_tick && !w_ms_full) ? r_ms_cnt + 1'b1 : r_ms_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_arm        = 1'b0;
        w_capture    = 1'b0;
        w_expire     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_arm        = 1'b1;
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                // Edge has priority over an overflow in the same cycle.
                if (w_edge) begin
                    w_capture = 1'b1;
                end else if (w_tick && w_ms_full) begin
                    w_expire     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_period_ms;
    logic             r_period_vld;
    logic             r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_cnt     <= '0;
            r_period_ms  <= '0;
            r_period_vld <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_period_vld <= w_capture;

            if (w_arm || w_capture || w_expire) begin
                r_ms_cnt <= '0;
            end else if (r_state == S_MEASURE && w_tick) begin
                r_ms_cnt <= r_ms_cnt + 1'b1;
            end

            if (w_capture) begin
                r_period_ms <= w_capture_val;
            end

            if (w_arm) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef BLINK_METER_FULL_PERIOD_EN
    assign o_period_lvl = 1'b0;
`else
    logic r_period_lvl;

    // The level before the edge is the level held throughout the interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_lvl <= 1'b0;
        end else if (w_capture) begin
            r_period_lvl <= w_sync_d;
        end
    end

    assign o_period_lvl = r_period_lvl;
`endif

    assign o_period_ms  = r_period_ms;
    assign o_period_vld = r_period_vld;
    assign o_timeout    = r_timeout;

endmodule : blink_period_meter

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Receive-side counterpart of the board's LED blinker: measures the time between level changes of an asynchronous toggling input and reports it in whole milliseconds.
- Intended to sit next to the blinker on the same 50 MHz board, or on a second board reading a blinker's output.
- Output is a one-cycle valid pulse per measured interval, plus a sticky timeout flag when the input stops toggling.

Parameters:
- CLK_PER_MS, 50000, clk cycles per millisecond tick.
- CNT_W, 16, width of the millisecond counter and of period_ms.
- SYNC_STAGES, 2, synchronizer flop count (minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sig_in  in  1  asynchronous toggling input (e.g. GPIO from a blinker LED line)
- period_ms  out  CNT_W  last measured interval in whole ms; holds between updates
- period_vld  out  1  one-cycle pulse when period_ms updates
- period_lvl  out  1  input level during the measured interval (level before the edge)
- timeout  out  1  sticky flag: no edge for 2^CNT_W ms while measuring

Behaviour:
Reset state:
- Sync chain and delayed-sync flop = 0; prescaler = 0; ms_cnt = 0; state IDLE.
- period_ms = 0, period_vld = 0, period_lvl = 0, timeout = 0.
- Reset mid-operation discards the measurement in progress.

Edge detection and latency:
- edge = sync_out XOR sync_d, where sync_d is sync_out delayed one cycle.
- sig_in high at reset release yields one edge; it is handled as a normal IDLE arming edge.
- Latency: a sig_in change first sampled at clock edge 1 updates the outputs at clock edge SYNC_STAGES+1.

Prescaler and ms counter:
- On an edge cycle the prescaler loads 0; otherwise it increments.
- tick = (prescaler == CLK_PER_MS-1); on tick the prescaler wraps to 0.
- ms_cnt increments on each tick; it loads 0 on an edge.

FSM:
- IDLE:
  - Edge -> MEASURE; clear ms_cnt and the prescaler; clear timeout.
  - No period_vld (the first edge only arms).
  - Ticks are ignored.
- MEASURE, edge:
  - period_ms <= ms_cnt + (tick ? 1 : 0), saturated at 2^CNT_W-1.
  - period_lvl <= sync_d; period_vld <= 1 for one cycle; ms_cnt <= 0.
  - Stay in MEASURE.
  - Net result: period_ms = floor(interval_cycles / CLK_PER_MS).
- MEASURE, tick with no edge and ms_cnt == 2^CNT_W-1:
  - timeout <= 1; ms_cnt <= 0; go to IDLE.
  - period_ms and period_lvl hold.

Simultaneous events:
- Edge together with tick: the edge wins, the tick is counted into the captured value, and the prescaler restarts.
- Edge together with saturation: a valid measurement is produced and no timeout is raised.

Other rules:
- Consecutive edges one cycle apart yield period_ms = 0 with period_vld. No glitch filtering.
- period_vld is never high two cycles running unless edges occur on consecutive cycles.

Optional Feature:
- Macro: BLINK_METER_FULL_PERIOD_EN.
- Defined:
  - Only rising edges of sync_out count as edges. Falling edges are ignored completely: no prescaler restart, no capture.
  - period_ms reports the full period.
  - period_lvl is driven constant 0.
- Undefined: every toggle is an edge; the half-period and period_lvl behave as in Behaviour.

Decomposition:
- Shared package blink_pkg:
  - FSM state encoding (S_IDLE, S_MEASURE).
  - Default CLK_PER_MS_50MHZ = 50000 constant, shared with the blinker.
- Sub-module sync_edge_det:
  - Parameter SYNC_STAGES; ports clk, rst, async_in, sync_out, sync_d, rise, fall, any.
  - Reusable for the board's button inputs.

Test Plan:
All scenarios use CLK_PER_MS=10, CNT_W=4, SYNC_STAGES=2.
1. Hold rst 3 cycles with sig_in=0, then run 200 cycles with sig_in=0 -> all outputs 0, state IDLE, timeout never set.
2. Toggle sig_in every 35 cycles starting high -> first toggle gives no vld; each later toggle gives a 1-cycle period_vld with period_ms=3, and period_lvl alternates 1,0,1...
3. Toggle intervals of 30 then 29 cycles -> period_ms=3 (edge coincides with tick), then period_ms=2.
4. After arming, stop toggling -> timeout=1 at 160 cycles after the last edge, state IDLE, period_ms unchanged. Next toggle clears timeout with no vld; the following toggle after 50 cycles gives vld with period_ms=5.
5. 1-cycle high pulse on sig_in while in MEASURE -> vld with period_ms=floor(gap/10) at the rising edge, then vld with period_ms=0 and period_lvl=1 one cycle later. Assert rst 20 cycles into the next interval -> outputs 0; the next toggle only arms.
6. With BLINK_METER_FULL_PERIOD_EN defined, toggle every 35 cycles -> vld only on rising edges, period_ms=7, period_lvl=0.
